// File: rtl/multicycle_memory_pkg.sv
// Shared sizing constants for the backing memory and the cache fill FSMs that talk to it.
package multicycle_memory_pkg;

    localparam int ADDR_W_DEFAULT      = 16;
    localparam int DATA_W_DEFAULT      = 16;
    localparam int DEPTH_LOG2_DEFAULT  = 15;
    localparam int MEM_LATENCY_DEFAULT = 4;
    localparam int PEND_W              = 4;

endpackage

// File: rtl/multicycle_memory_delay_pipe.sv
// Fixed-depth delay line carrying read responses; payload only advances behind a valid
// so the last stage keeps showing the most recent response between pulses.
module multicycle_memory_delay_pipe #(
    parameter int STAGES = 4,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data
);

    logic [STAGES-1:0] vld_q;
    logic [ADDR_W-1:0] addr_q [STAGES];
    logic [DATA_W-1:0] data_q [STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= in_valid;
            if (in_valid) begin
                addr_q[0] <= in_addr;
                data_q[0] <= in_data;
            end
            for (int i = 1; i < STAGES; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    addr_q[i] <= addr_q[i-1];
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign out_addr  = addr_q[STAGES-1];
    assign out_data  = data_q[STAGES-1];

endmodule

// File: rtl/multicycle_memory.sv
// Word-organised backing memory below the cache fill FSMs: single-cycle silent writes,
// fully pipelined reads returning after LATENCY cycles.
module multicycle_memory
    import multicycle_memory_pkg::*;
#(
    parameter int    ADDR_W     = ADDR_W_DEFAULT,
    parameter int    DATA_W     = DATA_W_DEFAULT,
    parameter int    DEPTH_LOG2 = DEPTH_LOG2_DEFAULT,
    parameter int    LATENCY    = MEM_LATENCY_DEFAULT,
    parameter string INIT_FILE  = ""
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_en,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [PEND_W-1:0] pend_cnt
);

    logic [DATA_W-1:0]     mem [0:2**DEPTH_LOG2-1];
    logic [DEPTH_LOG2-1:0] word_idx;
    logic [ADDR_W-1:0]     word_addr;
    logic                  rd_accept;
    logic                  wr_accept;

    assign word_idx  = req_addr[DEPTH_LOG2:1];
    assign word_addr = req_addr & ~{{(ADDR_W-1){1'b0}}, 1'b1};
    assign rd_accept = req_en & ~req_wr & ~rst;
    assign wr_accept = req_en & req_wr & ~rst;

    // Array is deliberately outside reset so contents survive a pipeline flush.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[word_idx] <= req_wdata;
        end
    end

    // Stage 0 registers the combinational read, so a read sees the array as it was
    // before any write landing on the same edge.
    multicycle_memory_delay_pipe #(
        .STAGES (LATENCY),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_delay_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rd_accept),
        .in_addr   (word_addr),
        .in_data   (mem[word_idx]),
        .out_valid (rsp_valid),
        .out_addr  (rsp_addr),
        .out_data  (rsp_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_cnt <= '0;
        end else begin
            case ({rd_accept, rsp_valid})
                2'b10:   pend_cnt <= pend_cnt + PEND_W'(1);
                2'b01:   pend_cnt <= pend_cnt - PEND_W'(1);
                default: pend_cnt <= pend_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_memory.sv
// Scoreboard bench for multicycle_memory: directed scenarios followed by random traffic.
module tb_multicycle_memory;

    localparam int L = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_en = 1'b0;
    logic        req_wr = 1'b0;
    logic [15:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic [15:0] rsp_addr;
    logic [3:0]  pend_cnt;

    multicycle_memory #(
        .ADDR_W     (16),
        .DATA_W     (16),
        .DEPTH_LOG2 (15),
        .LATENCY    (L),
        .INIT_FILE  ("")
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_en    (req_en),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_addr  (rsp_addr),
        .pend_cnt  (pend_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          issue;
        int          due;
        logic [15:0] addr;
        logic [15:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] ref_mem [int];
    logic [15:0] last_data = '0;
    logic [15:0] last_addr = '0;
    bit          mon_on = 1'b0;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, req);
        end
    endtask

    // Monitor: compare outputs against the scoreboard every cycle, away from the edge.
    always @(negedge clk) begin
        if (mon_on) begin
            int pend_exp;
            pend_exp = 0;
            foreach (exp_q[i]) if (exp_q[i].issue < cyc) pend_exp++;
            check("pend_cnt", 32'(pend_cnt), 32'(pend_exp));
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                check("rsp_valid", 32'(rsp_valid), 32'd1);
                check("rsp_data", 32'(rsp_data), 32'(exp_q[0].data));
                check("rsp_addr", 32'(rsp_addr), 32'(exp_q[0].addr));
                last_data = exp_q[0].data;
                last_addr = exp_q[0].addr;
                void'(exp_q.pop_front());
            end else begin
                check("rsp_valid_idle", 32'(rsp_valid), 32'd0);
                check("rsp_data_hold", 32'(rsp_data), 32'(last_data));
                check("rsp_addr_hold", 32'(rsp_addr), 32'(last_addr));
            end
            if (rst) begin
                exp_q.delete();
                last_data = '0;
                last_addr = '0;
            end
        end
    end

    task automatic drive(input bit r, input bit en, input bit wr,
                         input logic [15:0] a, input logic [15:0] d);
        exp_t e;
        @(posedge clk);
        #1;
        rst       = r;
        req_en    = en;
        req_wr    = wr;
        req_addr  = a;
        req_wdata = d;
        if (!r && en) begin
            if (wr) begin
                ref_mem[int'(a >> 1)] = d;
            end else begin
                e.issue = cyc;
                e.due   = cyc + L;
                e.addr  = a & 16'hFFFE;
                e.data  = ref_mem.exists(int'(a >> 1)) ? ref_mem[int'(a >> 1)] : 16'hxxxx;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        drive(1'b0, 1'b1, 1'b1, a, d);
    endtask

    task automatic rd(input logic [15:0] a);
        drive(1'b0, 1'b1, 1'b0, a, 16'h0000);
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        mon_on = 1'b1;
        idle(3);

        wr(16'hFFF0, 16'h0001);
        rd(16'hFFF0);
        idle(L + 1);

        for (int i = 0; i < 8; i++) wr(16'hFFF0 + 16'(2 * i), 16'(i + 1));
        for (int i = 0; i < 8; i++) rd(16'hFFF0 + 16'(2 * i));
        idle(L + 2);

        rd(16'hFFF3);
        idle(L + 1);

        wr(16'h0024, 16'h0016);
        rd(16'h0024);
        wr(16'h0024, 16'hBEEF);
        rd(16'h0024);
        idle(L + 1);

        wr(16'h0020, 16'h1234);
        wr(16'h0022, 16'hA5A5);
        rd(16'h0020);
        rd(16'h0022);
        drive(1'b1, 1'b1, 1'b0, 16'h0024, 16'h0000);
        drive(1'b1, 1'b1, 1'b1, 16'h0022, 16'hDEAD);
        idle(L + 2);
        rd(16'h0022);
        idle(L + 1);

        for (int i = 0; i < 16; i++) wr(16'h0100 + 16'(2 * i), 16'($urandom));
        for (int i = 0; i < 400; i++) begin
            bit          r;
            bit          en;
            bit          w;
            logic [15:0] a;
            r  = ($urandom_range(0, 63) == 0);
            en = ($urandom_range(0, 3) != 0);
            w  = ($urandom_range(0, 2) == 0);
            a  = 16'h0100 + 16'($urandom_range(0, 31));
            drive(r, en, w, a, 16'($urandom));
        end
        idle(L + 3);

        check("drain_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
